// File: rtl/ram_port_arbiter_if.sv
// Requester/RAM-facing bundle for ram_port_arbiter. The arbiter uses the slave view; the
// requesters plus the RAM port A together form the master view.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_lock;
  logic [BeWidth-1:0]    req0_we;
  logic [BeWidth-1:0]    req1_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic [1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  ram_en;
  logic [BeWidth-1:0]    ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_lock, req0_we, req1_we, req0_addr, req1_addr,
           req0_wdata, req1_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_lock, req0_we, req1_we, req0_addr, req1_addr,
           req0_wdata, req1_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata, ram_en, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Zero-fills the RAM after reset, then round-robin shares RAM port A between two requesters.
// Optional ARB_LOCK_EN macro adds a sticky per-requester lock on the grant.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  output logic init_done,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic {StInit, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic                  init_done_q, init_done_d;
  logic [1:0]            rsp_valid_q;
  logic                  rr_last_q, rr_last_d;
  logic [1:0]            elig;
  logic [1:0]            grant;
  logic                  winner;

`ifdef ARB_LOCK_EN
  logic lock_active_q, lock_active_d;
  logic lock_id_q, lock_id_d;

  // A held lock masks the other requester even while the owner is idle.
  always_comb begin
    elig = bus.req_valid;
    if (lock_active_q) begin
      elig = bus.req_valid & (lock_id_q ? 2'b10 : 2'b01);
    end
  end

  always_comb begin
    lock_active_d = lock_active_q;
    lock_id_d     = lock_id_q;
    if (grant != 2'b00) begin
      lock_active_d = bus.req_lock[winner];
      lock_id_d     = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_active_q <= 1'b0;
      lock_id_q     <= 1'b0;
    end else begin
      lock_active_q <= lock_active_d;
      lock_id_q     <= lock_id_d;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
  assign elig        = bus.req_valid;
`endif

  always_comb begin
    grant = 2'b00;
    if (state_q == StRun) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  assign winner = grant[1];

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    init_done_d  = init_done_q;
    rr_last_d    = rr_last_q;
    bus.ram_en   = 1'b0;
    bus.ram_we   = '0;
    bus.ram_addr = bus.req0_addr;
    bus.ram_din  = bus.req0_wdata;
    unique case (state_q)
      StInit: begin
        bus.ram_en   = 1'b1;
        bus.ram_we   = '1;
        bus.ram_addr = init_addr_q;
        bus.ram_din  = '0;
        init_addr_d  = init_addr_q + ADDR_WIDTH'(1);
        if (init_addr_q == '1) begin
          state_d     = StRun;
          init_done_d = 1'b1;
        end
      end
      StRun: begin
        if (grant != 2'b00) begin
          bus.ram_en   = 1'b1;
          bus.ram_we   = winner ? bus.req1_we    : bus.req0_we;
          bus.ram_addr = winner ? bus.req1_addr  : bus.req0_addr;
          bus.ram_din  = winner ? bus.req1_wdata : bus.req0_wdata;
          rr_last_d    = winner;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 2'b00;
      rr_last_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done_q <= init_done_d;
      rsp_valid_q <= grant;
      rr_last_q   <= rr_last_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = bus.ram_dout;
  assign init_done     = init_done_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: constant vector table, hand sequences and random traffic
// checked against a word-array scoreboard with round-robin/lock grant rules.
module tb_ram_port_arbiter;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned Depth = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_done (init_done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // RAM port A stand-in: read-first, 1-cycle read latency, preloaded with garbage.
  logic [DW-1:0] ram_mem [Depth] = '{default: 32'hBADC0FFE};
  logic [DW-1:0] ram_dout_q = '0;
  always @(posedge clk) begin
    if (bus.ram_en) begin
      ram_dout_q <= ram_mem[bus.ram_addr];
      for (int b = 0; b < BW; b++) begin
        if (bus.ram_we[b]) ram_mem[bus.ram_addr][8*b +: 8] <= bus.ram_din[8*b +: 8];
      end
    end
  end
  assign bus.ram_dout = ram_dout_q;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_mem [Depth];
  int model_last;
  int model_lock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_grant(input logic [1:0] v);
    logic [1:0] m = v;
    if (model_lock == 0) m = v & 2'b01;
    else if (model_lock == 1) m = v & 2'b10;
    if (m == 2'b11) return (model_last == 0) ? 2'b10 : 2'b01;
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < Depth; i++) model_mem[i] = '0;
    model_last = 1;
    model_lock = -1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] lk,
                       input logic [3:0] we0, input logic [3:0] a0, input logic [31:0] wd0,
                       input logic [3:0] we1, input logic [3:0] a1, input logic [31:0] wd1);
    bus.req_valid  = v;
    bus.req_lock   = lk;
    bus.req0_we    = we0;
    bus.req0_addr  = a0;
    bus.req0_wdata = wd0;
    bus.req1_we    = we1;
    bus.req1_addr  = a1;
    bus.req1_wdata = wd1;
  endtask

  // One clock: check grant/RAM drive before the edge, response after it.
  task automatic step(output logic [1:0] rdy, output logic [1:0] rsp, output logic [31:0] rd);
    logic [1:0]  g;
    int          w;
    logic [3:0]  we;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd = '0;
    logic        is_rd  = 1'b0;
    @(negedge clk);
    g   = model_grant(bus.req_valid);
    rdy = bus.req_ready;
    chk("ready", 32'(rdy), 32'(g));
    chk("ram_en", 32'(bus.ram_en), 32'(|g));
    if (g != 2'b00) begin
      w  = g[1] ? 1 : 0;
      we = (w == 1) ? bus.req1_we    : bus.req0_we;
      a  = (w == 1) ? bus.req1_addr  : bus.req0_addr;
      wd = (w == 1) ? bus.req1_wdata : bus.req0_wdata;
      chk("ram_addr", 32'(bus.ram_addr), 32'(a));
      chk("ram_we", 32'(bus.ram_we), 32'(we));
      if (we != 4'b0) chk("ram_din", bus.ram_din, wd);
      is_rd  = (we == 4'b0);
      exp_rd = model_mem[a];
      model_mem[a] = merge(model_mem[a], wd, we);
      model_last = w;
`ifdef ARB_LOCK_EN
      model_lock = bus.req_lock[w] ? w : -1;
`endif
    end else begin
      chk("ram_we_idle", 32'(bus.ram_we), 32'h0);
    end
    @(posedge clk);
    #1;
    rsp = bus.rsp_valid;
    rd  = bus.rsp_rdata;
    chk("rsp_valid", 32'(rsp), 32'(g));
    if (is_rd) chk("rsp_rdata", rd, exp_rd);
  endtask

  // Counts edges from reset release to init_done; ready must stay low meanwhile.
  task automatic wait_init();
    int cnt = 0;
    drive(2'b11, 2'b00, 4'h0, 4'h1, '0, 4'h0, 4'h2, '0);
    @(negedge clk);
    rst_n = 1'b1;
    while (!init_done && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (!init_done) chk("init_ready", 32'(bus.req_ready), 32'h0);
    end
    chk("init_cycles", cnt, Depth);
    drive(2'b00, 2'b00, 4'h0, 4'h0, '0, 4'h0, 4'h0, '0);
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [3:0]  we0;
    logic [3:0]  a0;
    logic [31:0] wd0;
    logic [3:0]  we1;
    logic [3:0]  a1;
    logic [31:0] wd1;
    logic [1:0]  exp_rdy;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  logic [1:0]  rdy, rsp;
  logic [31:0] rd;
  logic        pend [2];
  logic [3:0]  cwe [2];
  logic [3:0]  ca [2];
  logic [31:0] cwd [2];
  logic        clk_lock [2];

  initial begin
    tbl[0]  = '{2'b01, 4'b0101, 4'd3, 32'hDEADBEEF, 4'h0, 4'd2, '0, 2'b01, 1'b0, '0};
    tbl[1]  = '{2'b01, 4'b0000, 4'd3, '0, 4'h0, 4'd2, '0, 2'b01, 1'b1, 32'h00AD00EF};
    for (int i = 2; i < 6; i++) tbl[i] = '{2'b10, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0, 2'b10, 1'b1, '0};
    for (int i = 6; i < 12; i++) begin
      tbl[i] = '{2'b11, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0, (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, '0};
    end
    tbl[12] = '{2'b00, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0, 2'b00, 1'b0, '0};

    // Reset state while rst_n is held low.
    drive(2'b11, 2'b00, 4'h0, 4'h1, '0, 4'h0, 4'h2, '0);
    #1;
    chk("rst_init_done", 32'(init_done), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_ram_en", 32'(bus.ram_en), 32'h1);
    chk("rst_ram_we", 32'(bus.ram_we), 32'hF);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
    chk("rst_ram_din", bus.ram_din, 32'h0);
    #20;
    wait_init();

    // Zero fill visible through A0.
    for (int i = 0; i < Depth; i++) begin
      drive(2'b01, 2'b00, 4'h0, 4'(i), '0, 4'h0, 4'h0, '0);
      step(rdy, rsp, rd);
      chk("fill_rsp", 32'(rsp), 32'h1);
      chk("fill_zero", rd, 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, 2'b00, tbl[i].we0, tbl[i].a0, tbl[i].wd0,
            tbl[i].we1, tbl[i].a1, tbl[i].wd1);
      step(rdy, rsp, rd);
      chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_rsp", i), 32'(rsp), 32'(tbl[i].exp_rdy));
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
    end

`ifdef ARB_LOCK_EN
    drive(2'b10, 2'b10, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    chk("lock_take", 32'(rdy), 32'h2);
    for (int i = 0; i < 2; i++) begin
      drive(2'b01, 2'b00, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0);
      step(rdy, rsp, rd);
      chk("lock_block", 32'(rdy), 32'h0);
    end
    drive(2'b11, 2'b00, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    chk("lock_release", 32'(rdy), 32'h2);
    drive(2'b01, 2'b00, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    chk("lock_after", 32'(rdy), 32'h1);
`endif

    // Random traffic; commands stay stable until granted.
    for (int r = 0; r < 2; r++) pend[r] = 1'b0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 9) < 6) begin
          pend[r]     = 1'b1;
          ca[r]       = 4'($urandom);
          cwe[r]      = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
          cwd[r]      = $urandom;
          clk_lock[r] = ($urandom_range(0, 3) == 0);
        end
      end
      drive({pend[1], pend[0]}, {clk_lock[1], clk_lock[0]},
            cwe[0], ca[0], cwd[0], cwe[1], ca[1], cwd[1]);
      step(rdy, rsp, rd);
      for (int r = 0; r < 2; r++) if (rdy[r]) pend[r] = 1'b0;
    end

    // Reset with a response in flight; fill must restart and erase addr 3.
    drive(2'b11, 2'b00, 4'h0, 4'd1, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    drive(2'b01, 2'b00, 4'hF, 4'd3, 32'h12345678, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    drive(2'b01, 2'b00, 4'h0, 4'd3, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    chk("pre_rst_rdata", rd, 32'h12345678);
    chk("pre_rst_rsp", 32'(rsp), 32'h1);
    drive(2'b00, 2'b00, 4'h0, 4'd3, '0, 4'h0, 4'd2, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("midrst_init_done", 32'(init_done), 32'h0);
    #20;
    wait_init();
    drive(2'b01, 2'b00, 4'h0, 4'd3, '0, 4'h0, 4'd2, '0);
    step(rdy, rsp, rd);
    chk("refill_addr3", rd, 32'h0);
    chk("refill_rsp", 32'(rsp), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares write/read port A of the dual-port byte-enable RAM between two requesters, A0 and A1.
- After reset it zero-fills the whole RAM, then arbitrates round-robin.
- One transfer is issued per cycle. Each transfer returns a one-cycle response pulse with RAM read data.
- Sits between the core-side requesters and the RAM instance. Port B stays directly wired to its consumer.

Parameters:
ADDR_WIDTH, 9, RAM word address width; depth = 2^ADDR_WIDTH words.
DATA_WIDTH, 32, word width; byte lanes = DATA_WIDTH/8 (must divide by 8).

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
init_done  out  1  high once zero-fill is complete.
req_valid  in  2  per-requester command valid (bit i = requester i).
req_ready  out  2  per-requester grant; a transfer occurs on valid&ready.
req_lock  in  2  per-requester lock hint (used only with ARB_LOCK_EN).
req0_we / req1_we  in  DATA_WIDTH/8  byte write enables; all-zero = read.
req0_addr / req1_addr  in  ADDR_WIDTH  word address.
req0_wdata / req1_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  2  one-cycle response pulse to the requester that transferred last cycle.
rsp_rdata  out  DATA_WIDTH  RAM port-A dout, shared by both requesters, qualified by rsp_valid.
ram_en  out  1  RAM port-A enable.
ram_we  out  DATA_WIDTH/8  RAM port-A byte write enables.
ram_addr  out  ADDR_WIDTH  RAM port-A address.
ram_din  out  DATA_WIDTH  RAM port-A write data.
ram_dout  in  DATA_WIDTH  RAM port-A read data, valid 1 cycle after ram_en.

Behaviour:
- Reset values (asynchronous on rst_n low): state=INIT, init_addr=0, init_done=0, rsp_valid=0, rr_last=1 (so A0 wins first), lock_owner=none.
- State INIT:
  - ram_en=1, ram_we=all ones, ram_addr=init_addr, ram_din=0; init_addr increments each cycle.
  - req_ready=0.
  - After writing address 2^ADDR_WIDTH-1: go to RUN, set init_done=1 on the next edge. INIT lasts exactly 2^ADDR_WIDTH cycles.
- State RUN, combinational grant:
  - If only one req_valid bit is set, that requester wins.
  - If both are set, the requester other than rr_last wins.
  - req_ready is one-hot to the winner and 0 when nothing is valid. req_ready may depend combinationally on req_valid.
- RAM drive in RUN:
  - ram_en = |req_valid.
  - ram_we, ram_addr, ram_din are muxed from the winner.
  - When idle: ram_en=0, ram_we=0, other RAM outputs hold the A0 values.
- On a transfer, rr_last <= winner. With no transfer, rr_last holds.
- Response:
  - rsp_valid[i] <= transfer by i this cycle, so it pulses exactly 1 cycle after the transfer.
  - rsp_rdata = ram_dout combinationally.
  - Responses are issued for writes too, as an ack; rsp_rdata content on a write follows RAM read-during-write behaviour and is don't-care.
  - No response back-pressure: requesters must accept the pulse.
- Back-to-back transfers are allowed every cycle. A requester holding valid continuously while the other idles is granted every cycle.
- Requesters must hold valid and command stable until ready.
- Reset mid-RUN: outstanding responses are dropped (rsp_valid cleared) and zero-fill restarts from address 0.

Optional Feature:
ARB_LOCK_EN
- Defined:
  - On a transfer by requester i with req_lock[i]=1, lock_owner <= i.
  - While lock_owner=i, only i can be granted; the other requester's ready stays 0 even if i is idle.
  - Lock releases on a transfer by i with req_lock[i]=0, or at reset.
  - rr_last updates as normal.
- Not defined: req_lock is ignored, no lock_owner register exists, and arbitration is pure round-robin.

Test Plan:
- Reset, ADDR_WIDTH=4 -> init_done rises after exactly 16 cycles. Reading all 16 addresses via A0 -> rsp_rdata=0 for each, one cycle after each transfer.
- A0 writes addr 3, data 0xDEADBEEF, we=4'b0101, then reads addr 3 -> rsp_rdata=0x00AD00EF; rsp_valid[0] pulses 1 cycle after each transfer.
- Both valid continuously for 6 cycles, addresses 1 (A0) and 2 (A1) -> grants alternate A0,A1,A0,A1,A0,A1 and rsp_valid alternates with 1-cycle lag.
- Only A1 valid for 4 cycles -> req_ready[1]=1 every cycle, 4 rsp_valid[1] pulses; A0 then becomes valid alongside A1 -> A0 is granted next.
- rst_n pulsed low during RUN with a transfer in flight -> rsp_valid=0 immediately; init_done=0 until a full re-fill, after which previously written addr 3 reads 0.
- ARB_LOCK_EN: A1 transfers with lock=1, then idles 2 cycles while A0 is valid -> req_ready[0]=0 throughout; A1 transfers with lock=0 -> A0 is granted the following cycle.
